// File: rtl/prco_fetch.sv
// prco_fetch: instruction fetch stage; owns the PC, addresses the async-read local memory, issues {instr, pc}.
// Latency: the word at q_mem_addr is captured on the fetch edge and is valid the following cycle; first fetch 2 edges after reset drops.
// Backpressure: i_p_stalled while q_p_valid freezes the PC and the presented word; redirect overrides the stall and discards it.
//
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_p_stalled           next stage cannot accept this cycle
//   q_p_valid/q_p_stalled presented word is valid / is being held
//   q_p_ce                fetch enable this cycle (combinational)
//   q_p_cp                one-cycle pipeline-clear pulse after a redirect
//   i_redirect(_pc)       branch/jump taken and its target word address
//   i_halt / q_halted     halt request (level) / halted status
//   q_mem_addr/i_mem_dout local memory address (= PC) and same-cycle read data
//   q_instr/q_instr_pc    fetched instruction and its PC
//
// Optional feature: define PRCO_FETCH_NOP_SQUASH_EN to drop all-zero (NOP) words
// instead of issuing them; the PC still advances past them.

module prco_fetch #(
    parameter logic [15:0] P_RESET_VECTOR = 16'h0000,
    parameter logic [15:0] P_PC_MAX       = 16'd255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_p_stalled,
    output logic        q_p_valid,
    output logic        q_p_stalled,
    output logic        q_p_ce,
    output logic        q_p_cp,
    input  logic        i_redirect,
    input  logic [15:0] i_redirect_pc,
    input  logic        i_halt,
    output logic        q_halted,
    output logic [15:0] q_mem_addr,
    input  logic [15:0] i_mem_dout,
    output logic [15:0] q_instr,
    output logic [15:0] q_instr_pc
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t      state_q;
    logic [15:0] pc_q;
    logic        valid_q;
    logic        cp_q;
    logic [15:0] instr_q;
    logic [15:0] instr_pc_q;

    logic [15:0] pc_inc_d;
    logic [15:0] redirect_pc_d;
    logic        stalled_d;
    logic        ce_d;

    // The PC wraps to zero past the top of local memory rather than
    // running off the end of it; out-of-range redirect targets do the same.
    assign pc_inc_d      = (pc_q == P_PC_MAX) ? 16'h0000 : pc_q + 16'd1;
    assign redirect_pc_d = (i_redirect_pc > P_PC_MAX) ? 16'h0000 : i_redirect_pc;

    // A stall only matters when there is actually a word being presented.
    assign stalled_d = valid_q && i_p_stalled;

    // Halt is acted on in the same cycle it is seen, so it suppresses the
    // fetch that would otherwise happen on the transition edge.
    assign ce_d = (state_q == ST_RUN) && !i_halt && !stalled_d && !i_redirect;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            pc_q       <= P_RESET_VECTOR;
            valid_q    <= 1'b0;
            cp_q       <= 1'b0;
            instr_q    <= 16'h0000;
            instr_pc_q <= 16'h0000;
        end else begin
            cp_q <= 1'b0;
            if (i_redirect) begin
                // Redirect wins over stall and halt; the state is left as is
                // so a redirect while halted just retargets the PC.
                pc_q    <= redirect_pc_d;
                valid_q <= 1'b0;
                cp_q    <= 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: state_q <= ST_RUN;
                    ST_RUN:  if (i_halt) state_q <= ST_HALT;
                    ST_HALT: if (!i_halt) state_q <= ST_RUN;
                    default: state_q <= ST_IDLE;
                endcase

                if (ce_d) begin
                    pc_q <= pc_inc_d;
`ifdef PRCO_FETCH_NOP_SQUASH_EN
                    // NOP words are skipped: the previous word stays on the
                    // outputs, but marked invalid.
                    if (i_mem_dout == 16'h0000) begin
                        valid_q <= 1'b0;
                    end else begin
                        instr_q    <= i_mem_dout;
                        instr_pc_q <= pc_q;
                        valid_q    <= 1'b1;
                    end
`else
                    instr_q    <= i_mem_dout;
                    instr_pc_q <= pc_q;
                    valid_q    <= 1'b1;
`endif
                end else if (!stalled_d) begin
                    // Presented word has been consumed and nothing replaces it.
                    valid_q <= 1'b0;
                end
            end
        end
    end

    assign q_p_valid   = valid_q;
    assign q_p_stalled = stalled_d;
    assign q_p_ce      = ce_d;
    assign q_p_cp      = cp_q;
    assign q_halted    = (state_q == ST_HALT);
    assign q_mem_addr  = pc_q;
    assign q_instr     = instr_q;
    assign q_instr_pc  = instr_pc_q;

endmodule

// File: tb/tb_prco_fetch.sv
// tb_prco_fetch: scenario tasks for prco_fetch with a 4-word local memory and P_PC_MAX=3.
// Issued words are scored against a queue of expected {instr, pc} pairs filled by each scenario.
// A word counts as issued when it is presented valid and not stalled.

module tb_prco_fetch;

    logic        i_clk;
    logic        i_reset;
    logic        i_p_stalled;
    logic        q_p_valid;
    logic        q_p_stalled;
    logic        q_p_ce;
    logic        q_p_cp;
    logic        i_redirect;
    logic [15:0] i_redirect_pc;
    logic        i_halt;
    logic        q_halted;
    logic [15:0] q_mem_addr;
    logic [15:0] i_mem_dout;
    logic [15:0] q_instr;
    logic [15:0] q_instr_pc;

    logic [15:0] mem [0:3];
    logic [31:0] exp_q [$];
    int          n_cmp = 0;
    int          n_bad = 0;

    prco_fetch #(
        .P_RESET_VECTOR (16'h0000),
        .P_PC_MAX       (16'd3)
    ) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_p_stalled   (i_p_stalled),
        .q_p_valid     (q_p_valid),
        .q_p_stalled   (q_p_stalled),
        .q_p_ce        (q_p_ce),
        .q_p_cp        (q_p_cp),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .i_halt        (i_halt),
        .q_halted      (q_halted),
        .q_mem_addr    (q_mem_addr),
        .i_mem_dout    (i_mem_dout),
        .q_instr       (q_instr),
        .q_instr_pc    (q_instr_pc)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Asynchronous-read local memory; addresses past the model read a marker.
    assign i_mem_dout = (q_mem_addr < 16'd4) ? mem[q_mem_addr[1:0]] : 16'hdead;

    // Scoreboard: pop and compare every word the DUT issues.
    always @(negedge i_clk) begin
        #1;
        if (!i_reset && q_p_valid && !i_p_stalled) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL issue_unexpected: got %h/%0d required none", q_instr, q_instr_pc);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if ({q_instr, q_instr_pc} !== e) begin
                    n_bad++;
                    $display("FAIL issue_word: got %h/%0d required %h/%0d",
                             q_instr, q_instr_pc, e[31:16], e[15:0]);
                end
            end
        end
    end

    task automatic push_exp(input logic [15:0] w, input logic [15:0] pc);
`ifdef PRCO_FETCH_NOP_SQUASH_EN
        if (w != 16'h0000) exp_q.push_back({w, pc});
`else
        exp_q.push_back({w, pc});
`endif
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_reset = 1'b1; i_p_stalled = 1'b0; i_halt = 1'b0;
        i_redirect = 1'b0; i_redirect_pc = 16'h0000;
        @(negedge i_clk);
        i_reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge i_clk);
        i_reset = 1'b1; i_p_stalled = 1'b1; i_halt = 1'b0; i_redirect = 1'b0;
        @(negedge i_clk);
        #1;
        n_cmp++; if (q_p_valid !== 1'b0)    begin n_bad++; $display("FAIL rst_valid: got %b required 0", q_p_valid); end
        n_cmp++; if (q_p_stalled !== 1'b0)  begin n_bad++; $display("FAIL rst_stalled: got %b required 0", q_p_stalled); end
        n_cmp++; if (q_p_ce !== 1'b0)       begin n_bad++; $display("FAIL rst_ce: got %b required 0", q_p_ce); end
        n_cmp++; if (q_p_cp !== 1'b0)       begin n_bad++; $display("FAIL rst_cp: got %b required 0", q_p_cp); end
        n_cmp++; if (q_halted !== 1'b0)     begin n_bad++; $display("FAIL rst_halted: got %b required 0", q_halted); end
        n_cmp++; if (q_mem_addr !== 16'h0)  begin n_bad++; $display("FAIL rst_addr: got %h required 0000", q_mem_addr); end
        n_cmp++; if (q_instr !== 16'h0)     begin n_bad++; $display("FAIL rst_instr: got %h required 0000", q_instr); end
        n_cmp++; if (q_instr_pc !== 16'h0)  begin n_bad++; $display("FAIL rst_instr_pc: got %h required 0000", q_instr_pc); end
        i_p_stalled = 1'b0;
    endtask

    task automatic test_stream();
        do_reset();
        push_exp(16'h20ab, 0); push_exp(16'h21cd, 1); push_exp(16'h0000, 2);
        push_exp(16'h22ef, 3); push_exp(16'h20ab, 0); push_exp(16'h21cd, 1);
        @(negedge i_clk); #1;
        n_cmp++; if (q_p_valid !== 1'b0) begin n_bad++; $display("FAIL stream_first_bubble: got %b required 0", q_p_valid); end
        n_cmp++; if (q_p_ce !== 1'b1)    begin n_bad++; $display("FAIL stream_ce: got %b required 1", q_p_ce); end
        @(negedge i_clk); #1;
        n_cmp++; if (q_p_valid !== 1'b1) begin n_bad++; $display("FAIL stream_first_valid: got %b required 1", q_p_valid); end
        n_cmp++; if (q_mem_addr !== 16'd1) begin n_bad++; $display("FAIL stream_addr: got %h required 0001", q_mem_addr); end
        repeat (5) @(negedge i_clk);
        #2;
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL stream_drain: got %0d left required 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_stall();
        do_reset();
        push_exp(16'h20ab, 0); push_exp(16'h21cd, 1); push_exp(16'h0000, 2); push_exp(16'h22ef, 3);
        repeat (3) @(negedge i_clk);
        i_p_stalled = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++; if (q_p_stalled !== 1'b1) begin n_bad++; $display("FAIL stall_flag: got %b required 1", q_p_stalled); end
            n_cmp++; if (q_p_ce !== 1'b0)      begin n_bad++; $display("FAIL stall_ce: got %b required 0", q_p_ce); end
            n_cmp++; if ({q_instr, q_instr_pc} !== {16'h21cd, 16'd1})
                begin n_bad++; $display("FAIL stall_hold: got %h/%0d required 21cd/1", q_instr, q_instr_pc); end
            n_cmp++; if (q_mem_addr !== 16'd2) begin n_bad++; $display("FAIL stall_addr: got %h required 0002", q_mem_addr); end
            @(negedge i_clk);
        end
        i_p_stalled = 1'b0;
        repeat (2) @(negedge i_clk);
        #2;
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL stall_drain: got %0d left required 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_redirect();
        do_reset();
        push_exp(16'h20ab, 0); push_exp(16'h22ef, 3); push_exp(16'h20ab, 0); push_exp(16'h21cd, 1);
        repeat (2) @(negedge i_clk);
        i_redirect = 1'b1; i_redirect_pc = 16'd3;
        #1;
        n_cmp++; if (q_p_ce !== 1'b0) begin n_bad++; $display("FAIL redir_ce: got %b required 0", q_p_ce); end
        @(negedge i_clk);
        i_redirect = 1'b0;
        #1;
        n_cmp++; if (q_p_cp !== 1'b1)      begin n_bad++; $display("FAIL redir_cp: got %b required 1", q_p_cp); end
        n_cmp++; if (q_p_valid !== 1'b0)   begin n_bad++; $display("FAIL redir_bubble: got %b required 0", q_p_valid); end
        n_cmp++; if (q_mem_addr !== 16'd3) begin n_bad++; $display("FAIL redir_addr: got %h required 0003", q_mem_addr); end
        @(negedge i_clk); #1;
        n_cmp++; if (q_p_cp !== 1'b0) begin n_bad++; $display("FAIL redir_cp_pulse: got %b required 0", q_p_cp); end
        repeat (2) @(negedge i_clk);
        #2;
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL redir_drain: got %0d left required 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_redirect_range();
        do_reset();
        push_exp(16'h20ab, 0); push_exp(16'h21cd, 1); push_exp(16'h20ab, 0); push_exp(16'h21cd, 1);
        repeat (3) @(negedge i_clk);
        i_redirect = 1'b1; i_redirect_pc = 16'h0010;
        @(negedge i_clk);
        i_redirect = 1'b0;
        #1;
        n_cmp++; if (q_p_cp !== 1'b1)      begin n_bad++; $display("FAIL range_cp: got %b required 1", q_p_cp); end
        n_cmp++; if (q_mem_addr !== 16'd0) begin n_bad++; $display("FAIL range_addr: got %h required 0000", q_mem_addr); end
        repeat (2) @(negedge i_clk);
        #2;
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL range_drain: got %0d left required 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_halt();
        do_reset();
        push_exp(16'h20ab, 0); push_exp(16'h21cd, 1); push_exp(16'h0000, 2);
        push_exp(16'h22ef, 3); push_exp(16'h22ef, 3);
        repeat (3) @(negedge i_clk);
        i_halt = 1'b1;
        #1;
        n_cmp++; if (q_p_ce !== 1'b0) begin n_bad++; $display("FAIL halt_ce: got %b required 0", q_p_ce); end
        @(negedge i_clk); #1;
        n_cmp++; if (q_halted !== 1'b1)    begin n_bad++; $display("FAIL halt_flag: got %b required 1", q_halted); end
        n_cmp++; if (q_p_valid !== 1'b0)   begin n_bad++; $display("FAIL halt_drain: got %b required 0", q_p_valid); end
        n_cmp++; if (q_mem_addr !== 16'd2) begin n_bad++; $display("FAIL halt_addr: got %h required 0002", q_mem_addr); end
        @(negedge i_clk);
        i_halt = 1'b0;
        #1;
        n_cmp++; if (q_halted !== 1'b1) begin n_bad++; $display("FAIL halt_hold: got %b required 1", q_halted); end
        @(negedge i_clk); #1;
        n_cmp++; if (q_halted !== 1'b0) begin n_bad++; $display("FAIL halt_release: got %b required 0", q_halted); end
        n_cmp++; if (q_p_ce !== 1'b1)   begin n_bad++; $display("FAIL halt_resume_ce: got %b required 1", q_p_ce); end
        repeat (2) @(negedge i_clk);
        i_halt = 1'b1;
        @(negedge i_clk);
        i_redirect = 1'b1; i_redirect_pc = 16'd3;
        #1;
        n_cmp++; if (q_halted !== 1'b1)    begin n_bad++; $display("FAIL halt2_flag: got %b required 1", q_halted); end
        n_cmp++; if (q_mem_addr !== 16'd0) begin n_bad++; $display("FAIL halt2_wrap_addr: got %h required 0000", q_mem_addr); end
        @(negedge i_clk);
        i_redirect = 1'b0;
        #1;
        n_cmp++; if (q_halted !== 1'b1)    begin n_bad++; $display("FAIL halt_redir_state: got %b required 1", q_halted); end
        n_cmp++; if (q_p_cp !== 1'b1)      begin n_bad++; $display("FAIL halt_redir_cp: got %b required 1", q_p_cp); end
        n_cmp++; if (q_mem_addr !== 16'd3) begin n_bad++; $display("FAIL halt_redir_addr: got %h required 0003", q_mem_addr); end
        @(negedge i_clk);
        i_halt = 1'b0;
        @(negedge i_clk); #1;
        n_cmp++; if (q_halted !== 1'b0) begin n_bad++; $display("FAIL halt2_release: got %b required 0", q_halted); end
        @(negedge i_clk); #1;
        n_cmp++; if ({q_p_valid, q_instr, q_instr_pc} !== {1'b1, 16'h22ef, 16'd3})
            begin n_bad++; $display("FAIL halt_redir_word: got %b %h/%0d required 1 22ef/3", q_p_valid, q_instr, q_instr_pc); end
        #1;
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL halt_queue: got %0d left required 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        do_reset();
        push_exp(16'h20ab, 0);
        repeat (3) @(negedge i_clk);
        i_reset = 1'b1; i_p_stalled = 1'b1; i_halt = 1'b1;
        i_redirect = 1'b1; i_redirect_pc = 16'd2;
        @(negedge i_clk); #1;
        n_cmp++; if ({q_p_valid, q_p_cp, q_halted, q_p_ce} !== 4'b0000)
            begin n_bad++; $display("FAIL mid_rst_ctl: got %b required 0000", {q_p_valid, q_p_cp, q_halted, q_p_ce}); end
        n_cmp++; if ({q_mem_addr, q_instr, q_instr_pc} !== 48'h0)
            begin n_bad++; $display("FAIL mid_rst_data: got %h %h %h required 0", q_mem_addr, q_instr, q_instr_pc); end
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL mid_rst_queue: got %0d left required 0", exp_q.size()); end
        exp_q.delete();
        i_p_stalled = 1'b0; i_halt = 1'b0; i_redirect = 1'b0;
    endtask

    initial begin
        mem[0] = 16'h20ab; mem[1] = 16'h21cd; mem[2] = 16'h0000; mem[3] = 16'h22ef;
        i_reset = 1'b1; i_p_stalled = 1'b0; i_halt = 1'b0;
        i_redirect = 1'b0; i_redirect_pc = 16'h0000;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_range();
        test_halt();
        test_reset_mid();
        repeat (2) @(negedge i_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
